tf_key_extender: RTL and testbench



---
 rtl/tf_key_extender.sv | 146 ++++++++++++++
 tb/tb_tf_key_extender.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tf_key_extender.sv
// ---------------------------------------------------------------------------
// tf_key_extender
//   Upstream feeder for tf_key_scheduler (Threefish-1024). Accepts a 1024-bit
//   key and a 128-bit tweak, then builds:
//     - the extended key: k0..k15 plus parity word k16 = C240 ^ k0 ^ ... ^ k15
//     - the extended tweak: t0, t1 and t2 = t0 ^ t1
//   The parity is folded over N = 16/WORDS_PER_CYCLE cycles, which bounds the
//   XOR depth. The result is held until the consumer acknowledges it.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_valid   key_in/tweak_in valid (sampled only in IDLE)
//   in_ready   high in IDLE
//   key_in     k_i at [64i+63:64i]
//   tweak_in   t0 at [63:0], t1 at [127:64]
//   out_valid  high in DONE; key_out/tweak_out complete and stable
//   out_ack    consumer took the result (sampled only in DONE)
//   key_out    [1023:0] latched key, [1087:1024] k16
//   tweak_out  [127:0] latched tweak, [191:128] t2
//   busy       high in ACCUM
//
// Optional build macro
//   TF_KEY_ZEROIZE_EN : on the acknowledge edge, clear the outputs, the
//                       latched words and the accumulator.
// ---------------------------------------------------------------------------
module tf_key_extender #(
  parameter int          WORDS_PER_CYCLE = 1,
  parameter logic [63:0] C240            = 64'h1BD11BDAA9FC1A22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1023:0] key_in,
  input  logic [127:0]  tweak_in,
  output logic          out_valid,
  input  logic          out_ack,
  output logic [1087:0] key_out,
  output logic [191:0]  tweak_out,
  output logic          busy
);

  localparam int         N    = 16 / WORDS_PER_CYCLE;
  localparam logic [4:0] LAST = 5'(N - 1);

  generate
    if (!(WORDS_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_wpc
      $error("tf_key_extender: WORDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t          state_q, state_d;
  logic [1023:0]   key_q,   key_d;
  logic [127:0]    tweak_q, tweak_d;
  logic [63:0]     t2_q,    t2_d;
  logic [63:0]     acc_q,   acc_d;
  logic [63:0]     k16_q,   k16_d;
  logic [4:0]      cnt_q,   cnt_d;
  logic [63:0]     fold;

  // XOR of this cycle's slice of key words. cnt_q is always in 0..N-1
  // (cleared on accept and on the final fold), so the index stays in range.
  always_comb begin
    fold = '0;
    for (int j = 0; j < WORDS_PER_CYCLE; j++) begin
      fold = fold ^ key_q[64*(int'(cnt_q)*WORDS_PER_CYCLE + j) +: 64];
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    tweak_d = tweak_q;
    t2_d    = t2_q;
    acc_d   = acc_q;
    k16_d   = k16_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          key_d   = key_in;
          tweak_d = tweak_in;
          t2_d    = tweak_in[63:0] ^ tweak_in[127:64];
          acc_d   = C240;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q ^ fold;
        if (cnt_q == LAST) begin
          // k16 is only published here, so partial parity never reaches key_out
          k16_d   = acc_q ^ fold;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ack) begin
          state_d = IDLE;
`ifdef TF_KEY_ZEROIZE_EN
          key_d   = '0;
          tweak_d = '0;
          t2_d    = '0;
          acc_d   = '0;
          k16_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      tweak_q <= '0;
      t2_q    <= '0;
      acc_q   <= '0;
      k16_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      tweak_q <= tweak_d;
      t2_q    <= t2_d;
      acc_q   <= acc_d;
      k16_q   <= k16_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign key_out   = {k16_q, key_q};
  assign tweak_out = {t2_q, tweak_q};

endmodule

// File: tb/tb_tf_key_extender.sv
// ---------------------------------------------------------------------------
// tb_tf_key_extender
//   Four instances (WORDS_PER_CYCLE = 1, 2, 4, 16) share clock, reset and data
//   inputs; each has its own in_valid/out_ack. Expected k16/t2 come from the
//   Threefish parity definition evaluated directly on the key words.
// ---------------------------------------------------------------------------
module tb_tf_key_extender;

  localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    in_valid, out_ack, in_ready, out_valid, busy;
  logic [1023:0] key_in;
  logic [127:0]  tweak_in;
  logic [1087:0] key_out   [4];
  logic [191:0]  tweak_out [4];

  int vectors = 0;
  int errors  = 0;
  logic [63:0] prev_k16 [4];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      tf_key_extender #(
        .WORDS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : (g == 2 ? 4 : 16)))
      ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid[g]),
        .in_ready (in_ready[g]),
        .key_in   (key_in),
        .tweak_in (tweak_in),
        .out_valid(out_valid[g]),
        .out_ack  (out_ack[g]),
        .key_out  (key_out[g]),
        .tweak_out(tweak_out[g]),
        .busy     (busy[g])
      );
    end
  endgenerate

  function automatic int lat_of(input int i);
    return (i == 0) ? 16 : (i == 1) ? 8 : (i == 2) ? 4 : 1;
  endfunction

  // Reference: parity word is the constant XORed with all sixteen key words.
  function automatic logic [63:0] model_k16(input logic [1023:0] k);
    logic [63:0] p;
    p = C240;
    for (int w = 0; w < 16; w++) p = p ^ k[64*w +: 64];
    return p;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] rand_key();
    logic [1023:0] k;
    for (int w = 0; w < 32; w++) k[32*w +: 32] = $urandom;
    return k;
  endfunction

  // Accept a key on instance i and wait for out_valid, injecting ignored
  // in_valid/out_ack noise during ACCUM.
  task automatic start_txn(input int i, input logic [1023:0] k, input logic [127:0] t);
    int lat;
    key_in   = k;
    tweak_in = t;
    check("in_ready_idle", 256'(in_ready[i]), 256'(1'b1));
    in_valid[i] = 1'b1;
    tick();
    in_valid[i] = 1'b0;
    check("busy_after_accept", 256'(busy[i]), 256'(1'b1));
    check("in_ready_accum", 256'(in_ready[i]), 256'(1'b0));
    check("key_lo_at_accept", 256'(key_out[i][1023:0] === k), 256'(1'b1));
    check("tweak_lo_at_accept", 256'(tweak_out[i][127:0]), 256'(t));
    lat = 0;
    while (out_valid[i] !== 1'b1 && lat < 40) begin
      check("k16_hidden_in_accum", 256'(key_out[i][1087:1024]), 256'(prev_k16[i]));
      in_valid[i] = 1'($urandom_range(0, 1));
      out_ack[i]  = 1'($urandom_range(0, 1));
      key_in      = ~k;
      tweak_in    = ~t;
      tick();
      lat++;
    end
    in_valid[i] = 1'b0;
    out_ack[i]  = 1'b0;
    key_in      = k;
    tweak_in    = t;
    check("latency", 256'(lat), 256'(lat_of(i)));
    check("k16", 256'(key_out[i][1087:1024]), 256'(model_k16(k)));
    check("t2", 256'(tweak_out[i][191:128]), 256'(t[63:0] ^ t[127:64]));
    check("key_lo_done", 256'(key_out[i][1023:0] === k), 256'(1'b1));
    check("tweak_lo_done", 256'(tweak_out[i][127:0]), 256'(t));
    check("busy_done", 256'(busy[i]), 256'(1'b0));
    prev_k16[i] = model_k16(k);
  endtask

  // Hold in DONE for 'hold' cycles, then acknowledge with in_valid also high
  // (must not be taken on the ack edge).
  task automatic finish_txn(input int i, input logic [1023:0] k, input logic [127:0] t,
                            input int hold);
    for (int c = 0; c < hold; c++) begin
      tick();
      check("hold_out_valid", 256'(out_valid[i]), 256'(1'b1));
      check("hold_in_ready", 256'(in_ready[i]), 256'(1'b0));
      check("hold_k16", 256'(key_out[i][1087:1024]), 256'(model_k16(k)));
      check("hold_key_lo", 256'(key_out[i][1023:0] === k), 256'(1'b1));
    end
    out_ack[i]  = 1'b1;
    in_valid[i] = 1'b1;
    tick();
    out_ack[i]  = 1'b0;
    in_valid[i] = 1'b0;
    check("ack_out_valid", 256'(out_valid[i]), 256'(1'b0));
    check("ack_in_ready", 256'(in_ready[i]), 256'(1'b1));
    check("ack_no_accept", 256'(busy[i]), 256'(1'b0));
`ifdef TF_KEY_ZEROIZE_EN
    check("zeroize_key", 256'(key_out[i] === '0), 256'(1'b1));
    check("zeroize_tweak", 256'(tweak_out[i]), 256'(0));
    prev_k16[i] = '0;
`else
    check("retain_key_lo", 256'(key_out[i][1023:0] === k), 256'(1'b1));
    check("retain_k16", 256'(key_out[i][1087:1024]), 256'(model_k16(k)));
    check("retain_tweak", 256'(tweak_out[i]), 256'({t[63:0] ^ t[127:64], t}));
`endif
    tick();
    check("idle_stays", 256'({in_ready[i], busy[i]}), 256'(2'b10));
  endtask

  initial begin
    logic [1023:0] k;
    logic [127:0]  t;
    int            inst;

    in_valid = '0;
    out_ack  = '0;
    key_in   = '0;
    tweak_in = '0;
    reset    = 1'b0;
    for (int i = 0; i < 4; i++) prev_k16[i] = '0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("rst_flags", 256'({in_ready[i], out_valid[i], busy[i]}), 256'(3'b100));
      check("rst_key_out", 256'(key_out[i] === '0), 256'(1'b1));
      check("rst_tweak_out", 256'(tweak_out[i]), 256'(0));
    end
    reset = 1'b1;
    tick();

    // Zero input, WPC = 1
    start_txn(0, '0, '0);
    check("zero_k16_const", 256'(key_out[0][1087:1024]), 256'(64'h1BD11BDAA9FC1A22));
    finish_txn(0, '0, '0, 1);

    // Single word set
    k = '0;
    k[63:0] = 64'hFFFFFFFFFFFFFFFF;
    t = {64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF};
    start_txn(0, k, t);
    check("single_k16_const", 256'(key_out[0][1087:1024]), 256'(64'hE42EE4255603E5DD));
    check("single_t2_const", 256'(tweak_out[0][191:128]), 256'(64'hFEDCBA9876543210));
    finish_txn(0, k, t, 10);

    // k_i = i on every width
    for (int w = 0; w < 16; w++) k[64*w +: 64] = 64'(w);
    t = {64'h5555AAAA5555AAAA, 64'h0F0F0F0FF0F0F0F0};
    for (int i = 0; i < 4; i++) begin
      start_txn(i, k, t);
      check("ramp_k16_const", 256'(key_out[i][1087:1024]), 256'(C240));
      finish_txn(i, k, t, 2);
    end

    // Acknowledge to an idle instance is ignored
    out_ack[1] = 1'b1;
    tick();
    out_ack[1] = 1'b0;
    check("idle_ack_ignored", 256'({in_ready[1], out_valid[1], busy[1]}), 256'(3'b100));

    // Reset in the middle of ACCUM
    k = rand_key();
    t = {$urandom, $urandom, $urandom, $urandom};
    key_in      = k;
    tweak_in    = t;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (6) tick();
    check("mid_busy", 256'(busy[0]), 256'(1'b1));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_flags", 256'({in_ready[0], out_valid[0], busy[0]}), 256'(3'b100));
    check("midrst_key_out", 256'(key_out[0] === '0), 256'(1'b1));
    check("midrst_tweak_out", 256'(tweak_out[0]), 256'(0));
    for (int i = 0; i < 4; i++) prev_k16[i] = '0;
    k = rand_key();
    start_txn(0, k, t);
    finish_txn(0, k, t, 0);

    // Randomized transactions across widths
    for (int r = 0; r < 10; r++) begin
      inst = int'($urandom_range(0, 3));
      k = rand_key();
      t = {$urandom, $urandom, $urandom, $urandom};
      start_txn(inst, k, t);
      finish_txn(inst, k, t, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
